// File: rtl/datapath_mc_pkg.sv
// Shared encodings for the multicycle datapath: ALU ops, shifter modes and sequencer states.
package datapath_mc_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_MVN = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOADA = 3'd1,
      LOADB = 3'd2,
      LOAD  = 3'd3,
      EXEC  = 3'd4,
      WB    = 3'd5
   } state_e;

   localparam int STATUS_W = 3;

endpackage

// File: rtl/regfile_p.sv
// General register file: synchronous write, combinational read.
// DATAPATH_MC_FAST_EN adds a second read port.
module regfile_p #(
   parameter int DW   = 16,
   parameter int NREG = 8,
   parameter int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [RW-1:0] wnum,
   input  logic [DW-1:0] wdata,
   input  logic [RW-1:0] rnum_a,
   output logic [DW-1:0] rdata_a
`ifdef DATAPATH_MC_FAST_EN
   ,
   input  logic [RW-1:0] rnum_b,
   output logic [DW-1:0] rdata_b
`endif
);

   logic [DW-1:0] regs_reg [NREG];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (we) begin
         regs_reg[wnum] <= wdata;
      end
   end

   assign rdata_a = regs_reg[rnum_a];
`ifdef DATAPATH_MC_FAST_EN
   assign rdata_b = regs_reg[rnum_b];
`endif

endmodule

// File: rtl/datapath_mc.sv
// Multicycle datapath with its own micro-sequencer: one start pulse per instruction, one done pulse back.
// DATAPATH_MC_FAST_EN merges LOADA/LOADB into a single LOAD state using a second read port.
module datapath_mc #(
   parameter int DW   = 16,
   parameter int NREG = 8,
   parameter int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [1:0]    alu_op,
   input  logic [1:0]    shift,
   input  logic [RW-1:0] rn,
   input  logic [RW-1:0] rm,
   input  logic [RW-1:0] rd,
   input  logic          a_zero,
   input  logic          use_imm,
   input  logic [DW-1:0] imm,
   input  logic          wb_en,
   input  logic          ext_write,
   input  logic [RW-1:0] ext_wnum,
   input  logic [DW-1:0] ext_wdata,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] c_out,
   output logic [2:0]    status
);
   import datapath_mc_pkg::*;

   state_e        state_reg, state_next;
   alu_op_e       alu_op_reg;
   shift_e        shift_reg;
   logic [RW-1:0] rn_reg, rm_reg, rd_reg;
   logic          a_zero_reg, use_imm_reg, wb_en_reg;
   logic [DW-1:0] imm_reg;
   logic [DW-1:0] a_reg, b_reg, c_reg;
   logic [STATUS_W-1:0] status_reg;

   logic          rf_we;
   logic [RW-1:0] rf_wnum, rf_rnum_a;
   logic [DW-1:0] rf_wdata, rf_rdata_a;
   logic          accept;
   logic [DW-1:0] ain, bin, b_shifted, alu_res;
   logic          alu_v;

   assign accept = (state_reg == IDLE) && start;

   // The register file has one write port: external writes own it in IDLE, writeback in WB.
   assign rf_we     = ((state_reg == IDLE) && ext_write) || ((state_reg == WB) && wb_en_reg);
   assign rf_wnum   = (state_reg == WB) ? rd_reg : ext_wnum;
   assign rf_wdata  = (state_reg == WB) ? c_reg : ext_wdata;
   assign rf_rnum_a = (state_reg == LOADB) ? rm_reg : rn_reg;

`ifdef DATAPATH_MC_FAST_EN
   logic [DW-1:0] rf_rdata_b;

   regfile_p #(.DW(DW), .NREG(NREG), .RW(RW)) u_rf (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (rf_we),
      .wnum    (rf_wnum),
      .wdata   (rf_wdata),
      .rnum_a  (rf_rnum_a),
      .rdata_a (rf_rdata_a),
      .rnum_b  (rm_reg),
      .rdata_b (rf_rdata_b)
   );
`else
   regfile_p #(.DW(DW), .NREG(NREG), .RW(RW)) u_rf (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (rf_we),
      .wnum    (rf_wnum),
      .wdata   (rf_wdata),
      .rnum_a  (rf_rnum_a),
      .rdata_a (rf_rdata_a)
   );
`endif

   always_comb begin
      b_shifted = b_reg;
      case (shift_reg)
         SH_LSL1: b_shifted = {b_reg[DW-2:0], 1'b0};
         SH_LSR1: b_shifted = {1'b0, b_reg[DW-1:1]};
         SH_ASR1: b_shifted = {b_reg[DW-1], b_reg[DW-1:1]};
         default: b_shifted = b_reg;
      endcase
   end

   assign ain = a_zero_reg ? '0 : a_reg;
   assign bin = use_imm_reg ? imm_reg : b_shifted;

   // Overflow: for SUB the effective B sign is inverted, so the "signs agree" test flips.
   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      case (alu_op_reg)
         ALU_ADD: begin
            alu_res = ain + bin;
            alu_v   = (ain[DW-1] == bin[DW-1]) && (alu_res[DW-1] != ain[DW-1]);
         end
         ALU_SUB: begin
            alu_res = ain - bin;
            alu_v   = (ain[DW-1] != bin[DW-1]) && (alu_res[DW-1] != ain[DW-1]);
         end
         ALU_AND: alu_res = ain & bin;
         default: alu_res = ~bin;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      busy       = (state_reg != IDLE);
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
`ifdef DATAPATH_MC_FAST_EN
               state_next = LOAD;
`else
               state_next = LOADA;
`endif
            end
         end
         LOADA:   state_next = LOADB;
         LOADB:   state_next = EXEC;
         LOAD:    state_next = EXEC;
         EXEC:    state_next = WB;
         WB: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         alu_op_reg  <= ALU_ADD;
         shift_reg   <= SH_NONE;
         rn_reg      <= '0;
         rm_reg      <= '0;
         rd_reg      <= '0;
         a_zero_reg  <= 1'b0;
         use_imm_reg <= 1'b0;
         wb_en_reg   <= 1'b0;
         imm_reg     <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         c_reg       <= '0;
         status_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            alu_op_reg  <= alu_op_e'(alu_op);
            shift_reg   <= shift_e'(shift);
            rn_reg      <= rn;
            rm_reg      <= rm;
            rd_reg      <= rd;
            a_zero_reg  <= a_zero;
            use_imm_reg <= use_imm;
            wb_en_reg   <= wb_en;
            imm_reg     <= imm;
         end
         if (state_reg == LOADA) a_reg <= rf_rdata_a;
         if (state_reg == LOADB) b_reg <= rf_rdata_a;
`ifdef DATAPATH_MC_FAST_EN
         if (state_reg == LOAD) begin
            a_reg <= rf_rdata_a;
            b_reg <= rf_rdata_b;
         end
`endif
         if (state_reg == EXEC) begin
            c_reg      <= alu_res;
            status_reg <= {(alu_res == '0), alu_res[DW-1], alu_v};
         end
      end
   end

   assign c_out  = c_reg;
   assign status = status_reg;

endmodule

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
- Parametrised multicycle successor to the lab datapath: register file, A/B operand registers, shifter, ALU, result register C and status flags (Z, N, V).
- Has its own micro-sequencer, so the caller issues one start pulse per instruction and gets a done pulse. It does not drive vsel/loada/loadb/loadc/loads externally.
- Sits between the instruction decoder and the memory/IO stage of the CPU.

Parameters:
- DW, 16, datapath width in bits (minimum 4).
- NREG, 8, number of general registers (power of 2, minimum 2).
- RW, $clog2(NREG), register index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  instruction request; sampled only in IDLE.
- alu_op  input  2  00 ADD, 01 SUB, 10 AND, 11 MVN (~B).
- shift  input  2  00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
- rn  input  RW  A-operand register.
- rm  input  RW  B-operand register.
- rd  input  RW  writeback register.
- a_zero  input  1  force Ain=0 (MOV).
- use_imm  input  1  Bin=imm instead of shifted B.
- imm  input  DW  sign-extended immediate.
- wb_en  input  1  write C to rd at WB (0 = CMP style, flags only).
- ext_write  input  1  direct register write, honoured only in IDLE.
- ext_wnum  input  RW  target of ext_write.
- ext_wdata  input  DW  data for ext_write.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on instruction completion.
- c_out  output  DW  result register C.
- status  output  3  {Z, N, V}.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; all NREG registers, A, B, C and status cleared to 0; busy=0; done=0. Reset mid-instruction aborts with no writeback.
- Instruction fields (alu_op, shift, rn, rm, rd, a_zero, use_imm, imm, wb_en) are captured into internal registers when start is accepted. Inputs may change afterwards.
- State machine, one state per cycle:
  - IDLE -> LOADA on start.
  - LOADA (A<=R[rn]) -> LOADB.
  - LOADB (B<=R[rm]) -> EXEC.
  - EXEC (C<=ALU result; status<=flags) -> WB.
  - WB (R[rd]<=C if wb_en; done=1) -> IDLE.
- Latency: start edge to done high is 4 cycles. Back-to-back throughput is one instruction per 5 cycles, because start is only sampled in IDLE. start while busy is ignored, not queued.
- ALU datapath: Ain = a_zero ? 0 : A; Bin = use_imm ? imm : shift(B). Arithmetic is modulo 2^DW.
- Flags: Z=(result==0); N=result[DW-1]. For ADD/SUB, V = signed overflow (operand signs agree, and for SUB after inverting B, but the result sign differs). For AND/MVN, V=0.
- ext_write in IDLE writes ext_wdata to R[ext_wnum] at that edge. If it coincides with an accepted start, the write happens and the subsequent LOADA/LOADB read the new value. ext_write while busy is dropped.
- WB writes to rd==rn or rd==rm are legal; the new value is visible to the next instruction.
- c_out and status hold their values until the next EXEC or reset.

Optional Feature:
- DATAPATH_MC_FAST_EN defined: the register file has a second read port and LOADA/LOADB merge into one LOAD state (A and B loaded together). Latency becomes 3 cycles, throughput one instruction per 4 cycles.
- Not defined: single read port and the 4-cycle sequence above.
- Functional results are identical either way; only timing differs.

Decomposition:
- Package datapath_mc_pkg holds the alu_op encodings, shift encodings and the state enum (IDLE, LOADA, LOADB, LOAD, EXEC, WB).
- Sub-module regfile_p(DW, NREG): synchronous write, combinational read, second read port under DATAPATH_MC_FAST_EN.
- Shifter and ALU stay as combinational logic inside datapath_mc.

Test Plan:
- Reset, then ext_write R0=0x0007 and R1=0x0002; ADD rn=0, rm=1, rd=2, shift=01 -> done 4 cycles after start; c_out=0x000B; R2=0x000B; status=000.
- SUB rn=1, rm=0, wb_en=0 (2-7) -> c_out=0xFFFB; status Z=0 N=1 V=0; R[rd] unchanged.
- R0=0x7FFF, R1=0x0001, ADD -> c_out=0x8000; status=011 (N=1, V=1). Then SUB with R0=R1=0x1234 -> status=100.
- Pulse start again while busy and raise ext_write at the same time -> neither has any effect; exactly one done pulse.
- Drop reset_n during EXEC of an instruction writing R3 -> R3=0, c_out=0, busy=0 on the next cycle, no done pulse.
- ASR1 of 0x8004 into MVN, with a_zero=1 -> c_out=0x3FFD; with DATAPATH_MC_FAST_EN defined, done arrives 3 cycles after start.
